// File: rtl/jt12_bus_master.sv
// CPU-side initiator for the jt12 register bus: FIFO-queued {part,reg,data} writes replayed as
// busy poll / address write / busy poll / data write. Optional busy timeout: JT12_BUS_TIMEOUT_EN.
module jt12_bus_master #(
    parameter int FIFO_AW    = 2,
    parameter int STROBE_LEN = 2,
    parameter int BUSY_TMO   = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cen_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_part_i,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_data_i,
    output logic [7:0] ym_din_o,
    output logic [1:0] ym_addr_o,
    output logic       ym_cs_n_o,
    output logic       ym_wr_n_o,
    input  logic [7:0] ym_dout_i,
    output logic       idle_o,
    output logic       tmo_o
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam logic [3:0] STRB_LAST = 4'(STROBE_LEN - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POLL_A = 3'd1;
    localparam logic [2:0] S_WR_A   = 3'd2;
    localparam logic [2:0] S_GAP_A  = 3'd3;
    localparam logic [2:0] S_POLL_D = 3'd4;
    localparam logic [2:0] S_WR_D   = 3'd5;
    localparam logic [2:0] S_GAP_D  = 3'd6;

    logic [16:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         state_q, state_d;
    logic [16:0]        hold_q, hold_d;
    logic [3:0]         scnt_q, scnt_d;
    logic               cs_n_q, cs_n_d, wr_n_q, wr_n_d;
    logic [1:0]         addr_q, addr_d;
    logic [7:0]         din_q, din_d;
    logic               ready_q, idle_q;
    logic               push, pop, busy, tmo_hit;
    logic [6:0]         unused_dout;

    assign busy        = ym_dout_i[7];
    assign unused_dout = ym_dout_i[6:0];
    assign push        = req_valid_i && ready_q;
    assign cnt_d       = cnt_q + CW'(push) - CW'(pop);

`ifdef JT12_BUS_TIMEOUT_EN
    logic [7:0] bcnt_q, bcnt_d;
    logic       tmo_q;
    logic       in_poll;

    assign in_poll = (state_q == S_POLL_A) || (state_q == S_POLL_D);
    assign tmo_hit = in_poll && busy && (bcnt_q == 8'(BUSY_TMO - 1));
    assign tmo_o   = tmo_q;

    always_comb begin
        bcnt_d = bcnt_q;
        if (cen_i && in_poll)
            bcnt_d = (!busy || tmo_hit) ? 8'd0 : bcnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bcnt_q <= 8'd0;
            tmo_q  <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            tmo_q  <= cen_i && tmo_hit;
        end
    end
`else
    logic [7:0] unused_tmo;
    assign unused_tmo = 8'(BUSY_TMO);
    assign tmo_hit    = 1'b0;
    assign tmo_o      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        scnt_d  = scnt_q;
        pop     = 1'b0;
        if (cen_i) begin
            case (state_q)
                S_IDLE, S_GAP_D: begin
                    if (cnt_q != '0) begin
                        pop     = 1'b1;
                        hold_d  = mem_q[rd_ptr_q];
                        state_d = S_POLL_A;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_POLL_A: if (!busy || tmo_hit) begin state_d = S_WR_A; scnt_d = '0; end
                S_POLL_D: if (!busy || tmo_hit) begin state_d = S_WR_D; scnt_d = '0; end
                S_WR_A:   if (scnt_q == STRB_LAST) state_d = S_GAP_A; else scnt_d = scnt_q + 4'd1;
                S_WR_D:   if (scnt_q == STRB_LAST) state_d = S_GAP_D; else scnt_d = scnt_q + 4'd1;
                S_GAP_A:  state_d = S_POLL_D;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Bus pins are decoded from the next state so they change on the same edge as the FSM.
    // din is preloaded during the poll so it is already stable when the strobe falls.
    always_comb begin
        cs_n_d = 1'b1;
        wr_n_d = 1'b1;
        addr_d = addr_q;
        din_d  = din_q;
        case (state_d)
            S_POLL_A: begin cs_n_d = 1'b0; addr_d = 2'b00; din_d = hold_d[15:8]; end
            S_POLL_D: begin cs_n_d = 1'b0; addr_d = 2'b00; din_d = hold_d[7:0]; end
            S_WR_A: begin
                cs_n_d = 1'b0; wr_n_d = 1'b0;
                addr_d = {hold_d[16], 1'b0}; din_d = hold_d[15:8];
            end
            S_WR_D: begin
                cs_n_d = 1'b0; wr_n_d = 1'b0;
                addr_d = {hold_d[16], 1'b1}; din_d = hold_d[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {req_part_i, req_reg_i, req_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            hold_q   <= '0;
            scnt_q   <= '0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            addr_q   <= 2'b00;
            din_q    <= 8'h00;
            ready_q  <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            scnt_q   <= scnt_d;
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            ready_q  <= (cnt_d != CW'(DEPTH));
            idle_q   <= (state_d == S_IDLE) && (cnt_d == '0);
        end
    end

    assign req_ready_o = ready_q;
    assign idle_o      = idle_q;
    assign ym_cs_n_o   = cs_n_q;
    assign ym_wr_n_o   = wr_n_q;
    assign ym_addr_o   = addr_q;
    assign ym_din_o    = din_q;

endmodule

// File: tb/tb_jt12_bus_master.sv
// Directed bench for jt12_bus_master: bus monitor logs each strobe's {addr,din} and length.
module tb_jt12_bus_master;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       req_valid = 1'b0, req_ready, req_part = 1'b0;
    logic [7:0] req_reg = 8'h00, req_data = 8'h00;
    logic [7:0] ym_din, ym_dout = 8'h00;
    logic [1:0] ym_addr;
    logic       ym_cs_n, ym_wr_n, idle, tmo;

    int checks = 0, failures = 0;
    bit div6 = 1'b0, cen_en = 1'b1;
    int ph = 0;

    jt12_bus_master dut (
        .clk_i(clk), .rst_i(rst), .cen_i(cen),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_part_i(req_part), .req_reg_i(req_reg), .req_data_i(req_data),
        .ym_din_o(ym_din), .ym_addr_o(ym_addr), .ym_cs_n_o(ym_cs_n), .ym_wr_n_o(ym_wr_n),
        .ym_dout_i(ym_dout), .idle_o(idle), .tmo_o(tmo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div6) begin
            ph  = (ph == 5) ? 0 : ph + 1;
            cen = (ph == 0);
        end else begin
            cen = cen_en;
        end
    end

    // Bus monitor
    logic [9:0] log_q[$];
    int         len_q[$];
    int         polls = 0, unstable = 0, tmo_cnt = 0, slen = 0;
    logic       wr_prev = 1'b1;
    logic [9:0] cur = '0;

    always @(negedge clk) begin
        if (wr_prev && !ym_wr_n) begin
            log_q.push_back({ym_addr, ym_din});
            cur  = {ym_addr, ym_din};
            slen = 0;
        end
        if (!ym_wr_n) begin
            slen++;
            if ({ym_addr, ym_din} != cur) unstable++;
        end
        if (!wr_prev && ym_wr_n) len_q.push_back(slen);
        if (!ym_cs_n && ym_wr_n) polls++;
        if (tmo) tmo_cnt++;
        wr_prev = ym_wr_n;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        log_q.delete();
        len_q.delete();
        polls = 0; unstable = 0; tmo_cnt = 0;
    endtask

    task automatic push1(input logic p, input logic [7:0] r, input logic [7:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_part = p; req_reg = r; req_data = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (!idle && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(idle), 32'd1);
    endtask

    logic [16:0] vec [5];
    logic [4:0]  rdy;
    int          bw, n;

    initial begin
        vec[0] = {1'b0, 8'h10, 8'h11};
        vec[1] = {1'b1, 8'h20, 8'h21};
        vec[2] = {1'b0, 8'h30, 8'h31};
        vec[3] = {1'b1, 8'h40, 8'h41};
        vec[4] = {1'b0, 8'h50, 8'h51};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(ym_cs_n), 32'd1);
        chk("rst_wr_n", 32'(ym_wr_n), 32'd1);
        chk("rst_addr", 32'(ym_addr), 32'd0);
        chk("rst_din", 32'(ym_din), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Single write, cen=1
        clr();
        push1(1'b0, 8'h28, 8'hF0);
        wait_idle(100);
        chk("a_nwr", 32'(log_q.size()), 32'd2);
        chk("a_addr_ph", 32'(log_q[0]), 32'h028);
        chk("a_data_ph", 32'(log_q[1]), 32'h1F0);
        chk("a_len0", 32'(len_q[0]), 32'd2);
        chk("a_len1", 32'(len_q[1]), 32'd2);
        chk("a_polls", 32'(polls), 32'd2);
        chk("a_stable", 32'(unstable), 32'd0);

        // Five back-to-back pushes with the FSM frozen
        clr();
        cen_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            {req_part, req_reg, req_data} = vec[i];
            #1 rdy[i] = req_ready;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b_ready_pattern", 32'(rdy), 32'h0F);
        cen_en = 1'b1;
        wait_idle(300);
        chk("b_nwr", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_addr_ph%0d", i), 32'(log_q[2*i]), 32'({vec[i][16], 1'b0, vec[i][15:8]}));
            chk($sformatf("b_data_ph%0d", i), 32'(log_q[2*i+1]), 32'({vec[i][16], 1'b1, vec[i][7:0]}));
        end

        // Busy held during POLL_D
        clr();
        push1(1'b0, 8'hB6, 8'hC0);
        n = 0;
        while (ym_wr_n && n < 100) begin @(negedge clk); n++; end
        while (!ym_wr_n && n < 100) begin @(negedge clk); n++; end
        ym_dout = 8'h80;
        bw = 0;
        repeat (10) begin
            @(negedge clk);
            if (!ym_wr_n) bw++;
        end
        chk("c_wr_n_held", 32'(bw), 32'd0);
        chk("c_polling", 32'(ym_cs_n), 32'd0);
        ym_dout = 8'h00;
        @(negedge clk);
        chk("c_wr_d_start", 32'(ym_wr_n), 32'd0);
        wait_idle(100);
        chk("c_data_ph", 32'(log_q[1]), 32'h1C0);

        // cen 1-in-6
        clr();
        div6 = 1'b1;
        push1(1'b1, 8'hA4, 8'h22);
        wait_idle(400);
        div6 = 1'b0;
        chk("d_addr_ph", 32'(log_q[0]), 32'h2A4);
        chk("d_data_ph", 32'(log_q[1]), 32'h322);
        chk("d_len0", 32'(len_q[0]), 32'd12);
        chk("d_len1", 32'(len_q[1]), 32'd12);
        chk("d_polls", 32'(polls), 32'd12);
        chk("d_stable", 32'(unstable), 32'd0);

        // Reset during WR_D with another write queued
        clr();
        push1(1'b0, 8'h30, 8'h31);
        push1(1'b0, 8'h40, 8'h41);
        n = 0;
        while (!(!ym_wr_n && ym_addr[0]) && n < 100) begin @(negedge clk); n++; end
        chk("e_reached_wr_d", 32'(ym_addr[0] && !ym_wr_n), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("e_cs_n", 32'(ym_cs_n), 32'd1);
        chk("e_wr_n", 32'(ym_wr_n), 32'd1);
        chk("e_idle", 32'(idle), 32'd1);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("e_flushed_nwr", 32'(log_q.size()), 32'd2);
        chk("e_idle_after", 32'(idle), 32'd1);

        // Busy stuck high
        clr();
        ym_dout = 8'h80;
        push1(1'b0, 8'h2B, 8'h80);
        repeat (300) @(negedge clk);
`ifdef JT12_BUS_TIMEOUT_EN
        chk("f_tmo_once", 32'(tmo_cnt), 32'd1);
        chk("f_addr_issued", 32'(log_q.size()), 32'd1);
        repeat (300) @(negedge clk);
        chk("f_tmo_twice", 32'(tmo_cnt), 32'd2);
        wait_idle(100);
        chk("f_nwr", 32'(log_q.size()), 32'd2);
        ym_dout = 8'h00;
`else
        chk("f_no_tmo", 32'(tmo_cnt), 32'd0);
        chk("f_no_wr", 32'(log_q.size()), 32'd0);
        chk("f_cs_n_poll", 32'(ym_cs_n), 32'd0);
        chk("f_not_idle", 32'(idle), 32'd0);
        ym_dout = 8'h00;
        wait_idle(100);
        chk("f_nwr", 32'(log_q.size()), 32'd2);
`endif
        chk("f_data_ph", 32'(log_q[1]), 32'h180);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
